// File: rtl/scan_addr_gen_pkg.sv
// Shared types and default widths for the raster address sequencer.
package scan_pkg;
   localparam int DEF_ROW_W  = 4;
   localparam int DEF_COL_W  = 4;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/bounded_counter.sv
// Up-counter with synchronous clear/enable and a terminal-count flag.
module bounded_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         tc
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + W'(1);
   end

   assign tc = (cnt == term);
endmodule

// File: rtl/scan_addr_gen.sv
// Walks a rows x cols window and emits one address per accepted beat.
module scan_addr_gen
   import scan_pkg::*;
#(
   parameter int ROW_W  = DEF_ROW_W,
   parameter int COL_W  = DEF_COL_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  rows_last,
   input  logic [COL_W-1:0]  cols_last,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [ROW_W-1:0]  row_idx,
   output logic [COL_W-1:0]  col_idx,
   output logic              last,
   output logic              busy,
   output logic              done
);
   state_t            state;
   logic [ROW_W-1:0]  rows_last_q;
   logic [COL_W-1:0]  cols_last_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] row_base;
   logic              row_tc, col_tc;
   logic              start_acc, beat;

   assign start_acc = (state == ST_IDLE) && start;
   assign beat      = (state == ST_RUN) && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rows_last_q <= '0;
         cols_last_q <= '0;
         stride_q    <= '0;
         row_base    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               rows_last_q <= rows_last;
               cols_last_q <= cols_last;
               stride_q    <= stride;
               row_base    <= base_addr;
               state       <= ST_RUN;
            end
            ST_RUN: if (beat && col_tc) begin
               if (row_tc) state <= ST_DONE;
               else        row_base <= row_base + stride_q;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Column wraps on its own terminal count; row steps only on a column wrap.
   bounded_counter #(.W(COL_W)) u_col (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_acc || (beat && col_tc)),
      .en   (beat),
      .term (cols_last_q),
      .cnt  (col_idx),
      .tc   (col_tc)
   );

   bounded_counter #(.W(ROW_W)) u_row (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_acc || (beat && col_tc && row_tc)),
      .en   (beat && col_tc),
      .term (rows_last_q),
      .cnt  (row_idx),
      .tc   (row_tc)
   );

   assign valid = (state == ST_RUN);
   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_DONE);
   assign last  = valid && col_tc && row_tc;
   assign addr  = row_base + ADDR_W'(col_idx);
endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen with hand-computed address vectors.
module tb_scan_addr_gen;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] rows_last, cols_last;
   logic [7:0] base_addr, stride;
   logic       ready;
   logic       valid, last, busy, done;
   logic [7:0] addr;
   logic [3:0] row_idx, col_idx;

   int n_cmp = 0;
   int n_err = 0;

   scan_addr_gen dut (
      .clk(clk), .rst(rst), .start(start), .rows_last(rows_last),
      .cols_last(cols_last), .base_addr(base_addr), .stride(stride),
      .ready(ready), .valid(valid), .addr(addr), .row_idx(row_idx),
      .col_idx(col_idx), .last(last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_last"},  32'(last), 0);
      chk({tag, "_addr"},  32'(addr), 0);
      chk({tag, "_row"},   32'(row_idx), 0);
      chk({tag, "_col"},   32'(col_idx), 0);
   endtask

   task automatic go(input logic [3:0] rl, input logic [3:0] cl, input logic [7:0] b, input logic [7:0] s);
      rows_last = rl; cols_last = cl; base_addr = b; stride = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Expects beats on consecutive cycles (ready held high), then the DONE pulse.
   task automatic run_beats(input string tag, input int n, input int cl, input logic [7:0] e[8]);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, 32'(valid), 1);
         chk({tag, "_addr"},  32'(addr), 32'(e[i]));
         chk({tag, "_row"},   32'(row_idx), 32'(i / (cl + 1)));
         chk({tag, "_col"},   32'(col_idx), 32'(i % (cl + 1)));
         chk({tag, "_last"},  32'(last), (i == n - 1) ? 1 : 0);
         tick();
      end
      chk({tag, "_done"},    32'(done), 1);
      chk({tag, "_dvalid"},  32'(valid), 0);
      chk({tag, "_dbusy"},   32'(busy), 1);
      tick();
      chk({tag, "_done_end"}, 32'(done), 0);
      chk({tag, "_idle"},     32'(busy), 0);
   endtask

   initial begin
      logic [7:0] e_basic[8];
      logic [7:0] e_wrap[8];
      logic [7:0] e_one[8];
      logic       pat[4];
      int         i, cyc;

      e_basic = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h00, 8'h00};
      e_wrap  = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h7E, 8'h7F, 8'h80, 8'h81};
      e_one   = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      pat     = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; ready = 1'b1;
      rows_last = '0; cols_last = '0; base_addr = '0; stride = '0;
      tick();
      chk_idle_zero("reset");
      rst = 1'b0;
      tick();

      // Basic scan
      go(4'd1, 4'd2, 8'h10, 8'h08);
      run_beats("basic", 6, 2, e_basic);
      tick();

      // Back-pressure, ready pattern 1,0,0,1 repeating
      go(4'd1, 4'd2, 8'h10, 8'h08);
      i = 0; cyc = 0;
      while (i < 6 && cyc < 40) begin
         ready = pat[cyc % 4];
         chk("bp_valid", 32'(valid), 1);
         chk("bp_addr",  32'(addr), 32'(e_basic[i]));
         chk("bp_row",   32'(row_idx), 32'(i / 3));
         chk("bp_col",   32'(col_idx), 32'(i % 3));
         chk("bp_last",  32'(last), (i == 5) ? 1 : 0);
         if (ready) i++;
         tick();
         cyc++;
      end
      chk("bp_count", 32'(i), 6);
      chk("bp_done",  32'(done), 1);
      ready = 1'b1;
      tick();
      tick();

      // Single element
      go(4'd0, 4'd0, 8'h3C, 8'h55);
      run_beats("single", 1, 0, e_one);
      tick();

      // Wrap-around
      go(4'd1, 4'd3, 8'hFE, 8'h80);
      run_beats("wrap", 8, 3, e_wrap);
      tick();

      // Start while busy: new parameters held on the inputs during RUN
      go(4'd1, 4'd2, 8'h10, 8'h08);
      rows_last = 4'd0; cols_last = 4'd0; base_addr = 8'hA0; stride = 8'h01;
      start = 1'b1;
      run_beats("busy_start", 6, 2, e_basic);
      start = 1'b0;
      tick();

      // Reset on the 3rd beat
      go(4'd1, 4'd2, 8'h10, 8'h08);
      tick();
      tick();
      chk("rst_pre_addr", 32'(addr), 32'h12);
      #2 rst = 1'b1;
      #1 chk_idle_zero("rst_mid");
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_no_done", 32'(done), 0);
         chk("rst_no_busy", 32'(busy), 0);
      end
      go(4'd1, 4'd2, 8'h10, 8'h08);
      run_beats("post_rst", 6, 2, e_basic);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
